// File: rtl/mc_cu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes,
// FSM state encoding, ALU operation codes and datapath mux encodings.
package mc_cu_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // Encodings 14 and 15 are unused and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC    = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_I_EXEC  = 4'd10,
    S_I_WB    = 4'd11,
    S_JAL     = 4'd12,
    S_TRAP    = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    CL_MEM, CL_R, CL_BR, CL_J, CL_JAL, CL_I, CL_ILL
  } op_class_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_cu_if.sv
// Control unit <-> datapath bundle. The control unit is the master: it
// consumes the IR op field and memory ready, and drives all mux selects
// and write strobes.
interface mc_cu_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_wr;
  logic       pc_wr_cond;
  logic       br_ne;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_wr;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pc_wr, pc_wr_cond, br_ne, iord, mem_rd, mem_wr, ir_wr, reg_wr,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op,
           pc_src, illegal, state
  );

  modport slave (
    output op, mem_ready,
    input  pc_wr, pc_wr_cond, br_ne, iord, mem_rd, mem_wr, ir_wr, reg_wr,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op,
           pc_src, illegal, state
  );
endinterface

// File: rtl/mc_cu_opdec.sv
// Opcode classifier: maps the IR op field to an instruction class plus the
// ALU op and immediate extension used by I-type execute. Extended opcodes
// (bne/jal/andi/ori/slti/lui) are only legal when EXT_EN is set.
module mc_cu_opdec
  import mc_cu_pkg::*;
#(
  parameter bit EXT_EN = 1'b1
) (
  input  logic [5:0] i_op,
  output logic       o_legal,
  output op_class_e  o_cls,
  output logic [2:0] o_i_alu_op,
  output logic       o_ext_zero
);

  // Classify the opcode; anything unmatched stays CL_ILL.
  always_comb begin
    o_cls      = CL_ILL;
    o_i_alu_op = ALU_ADD;
    o_ext_zero = 1'b0;
    case (i_op)
      OP_R:         o_cls = CL_R;
      OP_LW, OP_SW: o_cls = CL_MEM;
      OP_BEQ:       o_cls = CL_BR;
      OP_J:         o_cls = CL_J;
      OP_ADDIU:     o_cls = CL_I;
      OP_BNE:       if (EXT_EN) o_cls = CL_BR;
      OP_JAL:       if (EXT_EN) o_cls = CL_JAL;
      OP_SLTI: if (EXT_EN) begin
        o_cls      = CL_I;
        o_i_alu_op = ALU_SLT;
      end
      OP_ANDI: if (EXT_EN) begin
        o_cls      = CL_I;
        o_i_alu_op = ALU_AND;
        o_ext_zero = 1'b1;
      end
      OP_ORI: if (EXT_EN) begin
        o_cls      = CL_I;
        o_i_alu_op = ALU_OR;
        o_ext_zero = 1'b1;
      end
      OP_LUI: if (EXT_EN) begin
        o_cls      = CL_I;
        o_i_alu_op = ALU_LUI;
      end
      default: ;
    endcase
    o_legal = (o_cls != CL_ILL);
  end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit. Moore FSM: every output is decoded from
// the state register, except ir_wr/pc_wr in FETCH which follow mem_ready.
// While rst_n is low the write/memory strobes and illegal are forced off.
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter bit EXT_EN   = 1'b1,
  parameter bit ILL_TRAP = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  mc_cu_if.master bus
);

  state_e     r_state;
  logic       w_legal;
  op_class_e  w_cls;
  logic [2:0] w_i_alu_op;
  logic       w_ext_zero_i;

  logic       w_pc_wr, w_pc_wr_cond, w_br_ne, w_iord;
  logic       w_mem_rd, w_mem_wr, w_ir_wr, w_reg_wr;
  logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_src;
  logic       w_alu_src_a, w_ext_zero, w_illegal;
  logic [2:0] w_alu_op;

  mc_cu_opdec #(.EXT_EN(EXT_EN)) u_opdec (
    .i_op       (bus.op),
    .o_legal    (w_legal),
    .o_cls      (w_cls),
    .o_i_alu_op (w_i_alu_op),
    .o_ext_zero (w_ext_zero_i)
  );

  // State register and next-state selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_cls)
            CL_MEM:  r_state <= S_MEM_ADR;
            CL_R:    r_state <= S_EXEC;
            CL_BR:   r_state <= S_BRANCH;
            CL_J:    r_state <= S_JUMP;
            CL_JAL:  r_state <= S_JAL;
            CL_I:    r_state <= S_I_EXEC;
            default: r_state <= ILL_TRAP ? S_TRAP : S_FETCH;
          endcase
        end
        S_MEM_ADR: r_state <= (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  if (bus.mem_ready) r_state <= S_MEM_WB;
        S_MEM_WR:  if (bus.mem_ready) r_state <= S_FETCH;
        S_EXEC:    r_state <= S_R_WB;
        S_I_EXEC:  r_state <= S_I_WB;
        S_TRAP:    r_state <= S_TRAP;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Per-state output decode.
  always_comb begin
    w_pc_wr      = 1'b0;
    w_pc_wr_cond = 1'b0;
    w_br_ne      = 1'b0;
    w_iord       = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_ir_wr      = 1'b0;
    w_reg_wr     = 1'b0;
    w_reg_dst    = RD_RT;
    w_mem_to_reg = M2R_ALU;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_ext_zero   = 1'b0;
    w_alu_op     = ALU_ADD;
    w_pc_src     = PCS_ALU;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_rd    = 1'b1;
        w_alu_src_b = SRCB_4;
        w_ir_wr     = bus.mem_ready;
        w_pc_wr     = bus.mem_ready;
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_BR;
        w_illegal   = ~w_legal;
      end
      S_MEM_ADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        w_mem_rd = 1'b1;
        w_iord   = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_wr     = 1'b1;
        w_mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        w_mem_wr = 1'b1;
        w_iord   = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        w_reg_wr  = 1'b1;
        w_reg_dst = RD_RD;
      end
      S_BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALU_SUB;
        w_pc_wr_cond = 1'b1;
        w_pc_src     = PCS_ALUOUT;
        w_br_ne      = (bus.op == OP_BNE);
      end
      S_JUMP: begin
        w_pc_wr  = 1'b1;
        w_pc_src = PCS_JUMP;
      end
      S_JAL: begin
        w_pc_wr      = 1'b1;
        w_pc_src     = PCS_JUMP;
        w_reg_wr     = 1'b1;
        w_reg_dst    = RD_RA;
        w_mem_to_reg = M2R_PC;
      end
      S_I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = w_i_alu_op;
        w_ext_zero  = w_ext_zero_i;
      end
      S_I_WB: begin
        w_reg_wr = 1'b1;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by rst_n so a mid-instruction reset stops writes at once.
  assign bus.pc_wr      = w_pc_wr & rst_n;
  assign bus.pc_wr_cond = w_pc_wr_cond & rst_n;
  assign bus.ir_wr      = w_ir_wr & rst_n;
  assign bus.reg_wr     = w_reg_wr & rst_n;
  assign bus.mem_rd     = w_mem_rd & rst_n;
  assign bus.mem_wr     = w_mem_wr & rst_n;
  assign bus.illegal    = w_illegal & rst_n;
  assign bus.br_ne      = w_br_ne;
  assign bus.iord       = w_iord;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.ext_zero   = w_ext_zero;
  assign bus.alu_op     = w_alu_op;
  assign bus.pc_src     = w_pc_src;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mc_cu.sv
// Directed bench for mc_cu. Three instances share op/mem_ready/rst_n:
// a = EXT_EN 1 / ILL_TRAP 1, b = EXT_EN 1 / ILL_TRAP 0, c = EXT_EN 0 / ILL_TRAP 1.
module tb_mc_cu;
  import mc_cu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] r_op;
  logic       r_mem_ready;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mc_cu_if u_if_a ();
  mc_cu_if u_if_b ();
  mc_cu_if u_if_c ();

  assign u_if_a.op = r_op;
  assign u_if_b.op = r_op;
  assign u_if_c.op = r_op;
  assign u_if_a.mem_ready = r_mem_ready;
  assign u_if_b.mem_ready = r_mem_ready;
  assign u_if_c.mem_ready = r_mem_ready;

  mc_cu #(.EXT_EN(1'b1), .ILL_TRAP(1'b1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(u_if_a));
  mc_cu #(.EXT_EN(1'b1), .ILL_TRAP(1'b0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(u_if_b));
  mc_cu #(.EXT_EN(1'b0), .ILL_TRAP(1'b1)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(u_if_c));

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int strobes_a();
    return int'({u_if_a.pc_wr, u_if_a.pc_wr_cond, u_if_a.ir_wr,
                 u_if_a.reg_wr, u_if_a.mem_rd, u_if_a.mem_wr});
  endfunction

  initial begin
    rst_n       = 1'b0;
    r_op        = OP_LW;
    r_mem_ready = 1'b1;

    // reset: FETCH but strobes forced off
    #2;
    check("rst_state",   int'(u_if_a.state), 0);
    check("rst_strobes", strobes_a(), 0);
    check("rst_illegal", int'(u_if_a.illegal), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("fetch_mem_rd", int'(u_if_a.mem_rd), 1);
    check("fetch_ir_wr",  int'(u_if_a.ir_wr), 1);
    check("fetch_pc_wr",  int'(u_if_a.pc_wr), 1);
    check("fetch_srcb",   int'(u_if_a.alu_src_b), 1);

    // FETCH stall
    r_mem_ready = 1'b0;
    #1;
    check("stall_ir_wr",  int'(u_if_a.ir_wr), 0);
    check("stall_pc_wr",  int'(u_if_a.pc_wr), 0);
    check("stall_mem_rd", int'(u_if_a.mem_rd), 1);
    tick();
    check("stall_state", int'(u_if_a.state), 0);
    r_mem_ready = 1'b1;

    // lw: 0,1,2,3,4,0
    tick();
    check("lw_s1",      int'(u_if_a.state), 1);
    check("lw_dec_srcb", int'(u_if_a.alu_src_b), 3);
    tick();
    check("lw_s2",      int'(u_if_a.state), 2);
    check("lw_adr_srca", int'(u_if_a.alu_src_a), 1);
    check("lw_adr_srcb", int'(u_if_a.alu_src_b), 2);
    tick();
    check("lw_s3",      int'(u_if_a.state), 3);
    check("lw_rd_mem_rd", int'(u_if_a.mem_rd), 1);
    check("lw_rd_iord", int'(u_if_a.iord), 1);
    tick();
    check("lw_s4",      int'(u_if_a.state), 4);
    check("lw_wb_reg_wr", int'(u_if_a.reg_wr), 1);
    check("lw_wb_m2r",  int'(u_if_a.mem_to_reg), 1);
    check("lw_wb_dst",  int'(u_if_a.reg_dst), 0);
    tick();
    check("lw_s0",      int'(u_if_a.state), 0);

    // sw with two wait cycles in MEM_WR
    r_op = OP_SW;
    tick();
    check("sw_s1", int'(u_if_a.state), 1);
    check("sw_dec_reg_wr", int'(u_if_a.reg_wr), 0);
    tick();
    check("sw_s2", int'(u_if_a.state), 2);
    tick();
    r_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sw_wr_state",  int'(u_if_a.state), 5);
      check("sw_wr_mem_wr", int'(u_if_a.mem_wr), 1);
      check("sw_wr_iord",   int'(u_if_a.iord), 1);
      check("sw_wr_reg_wr", int'(u_if_a.reg_wr), 0);
      if (i == 2) r_mem_ready = 1'b1;
      tick();
    end
    check("sw_s0", int'(u_if_a.state), 0);

    // bne then beq
    r_op = OP_BNE;
    tick();
    tick();
    check("bne_state",  int'(u_if_a.state), 8);
    check("bne_cond",   int'(u_if_a.pc_wr_cond), 1);
    check("bne_br_ne",  int'(u_if_a.br_ne), 1);
    check("bne_alu_op", int'(u_if_a.alu_op), 1);
    check("bne_pc_src", int'(u_if_a.pc_src), 1);
    check("bne_srca",   int'(u_if_a.alu_src_a), 1);
    tick();
    check("bne_s0", int'(u_if_a.state), 0);
    r_op = OP_BEQ;
    tick();
    tick();
    check("beq_state", int'(u_if_a.state), 8);
    check("beq_br_ne", int'(u_if_a.br_ne), 0);
    check("beq_cond",  int'(u_if_a.pc_wr_cond), 1);
    tick();
    check("beq_s0", int'(u_if_a.state), 0);

    // jal
    r_op = OP_JAL;
    tick();
    tick();
    check("jal_state",  int'(u_if_a.state), 12);
    check("jal_pc_wr",  int'(u_if_a.pc_wr), 1);
    check("jal_reg_wr", int'(u_if_a.reg_wr), 1);
    check("jal_dst",    int'(u_if_a.reg_dst), 2);
    check("jal_m2r",    int'(u_if_a.mem_to_reg), 2);
    check("jal_pc_src", int'(u_if_a.pc_src), 2);
    tick();
    check("jal_s0", int'(u_if_a.state), 0);

    // ori
    r_op = OP_ORI;
    tick();
    tick();
    check("ori_state",    int'(u_if_a.state), 10);
    check("ori_alu_op",   int'(u_if_a.alu_op), 4);
    check("ori_ext_zero", int'(u_if_a.ext_zero), 1);
    check("ori_srcb",     int'(u_if_a.alu_src_b), 2);
    tick();
    check("ori_wb_state", int'(u_if_a.state), 11);
    check("ori_wb_reg_wr", int'(u_if_a.reg_wr), 1);
    check("ori_wb_dst",   int'(u_if_a.reg_dst), 0);
    tick();
    check("ori_s0", int'(u_if_a.state), 0);

    // illegal opcode: a traps, b skips
    r_op = 6'b111111;
    tick();
    check("ill_dec_a", int'(u_if_a.illegal), 1);
    check("ill_dec_b", int'(u_if_b.illegal), 1);
    tick();
    check("ill_b_state", int'(u_if_b.state), 0);
    check("ill_b_flag",  int'(u_if_b.illegal), 0);
    for (int i = 0; i < 10; i++) begin
      check("trap_state",   int'(u_if_a.state), 13);
      check("trap_illegal", int'(u_if_a.illegal), 1);
      check("trap_strobes", strobes_a(), 0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("trap_rst_state",   int'(u_if_a.state), 0);
    check("trap_rst_illegal", int'(u_if_a.illegal), 0);
    tick();
    rst_n = 1'b1;

    // EXT_EN=0 rejects jal
    r_op = OP_JAL;
    tick();
    check("noext_ill_c", int'(u_if_c.illegal), 1);
    check("noext_ill_a", int'(u_if_a.illegal), 0);
    tick();
    check("noext_c_state", int'(u_if_c.state), 13);
    check("noext_a_state", int'(u_if_a.state), 12);
    tick();
    check("noext_a_s0", int'(u_if_a.state), 0);

    // reset asserted during MEM_WB
    r_op = OP_LW;
    tick();
    tick();
    tick();
    tick();
    check("mid_wb_state",  int'(u_if_a.state), 4);
    check("mid_wb_reg_wr", int'(u_if_a.reg_wr), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_reg_wr", int'(u_if_a.reg_wr), 0);
    check("mid_rst_state",  int'(u_if_a.state), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_cu.md
# mc_cu

Multi-cycle successor to the single-cycle MIPS control unit: a Moore-style FSM sequencing fetch, decode, execute, memory and write-back over several cycles, sharing one memory port and one ALU. Adds bne, jal, andi, ori, slti and lui. Adds a memory ready handshake and parametrised handling of illegal opcodes. Sits between the instruction register (op field) and the multi-cycle datapath muxes and write strobes.

## Interface
- EXT_EN, 1, 1 = decode bne/jal/andi/ori/slti/lui; 0 = those opcodes are illegal
- ILL_TRAP, 1, 1 = illegal opcode enters TRAP until reset; 0 = skip instruction and return to FETCH
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]; stable from DECODE until the next ir_wr
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_wr, pc_wr_cond, br_ne  out  1 each  unconditional PC write; branch PC write; invert zero test (bne)
- iord  out  1  0 = PC addresses memory, 1 = ALUOut
- mem_rd, mem_wr, ir_wr, reg_wr  out  1 each  strobes
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 ext imm, 11 sext imm<<2
- ext_zero  out  1  zero-extend imm (andi/ori)
- alu_op  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 lui
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
- illegal  out  1  unsupported opcode flag
- state  out  4  current state, debug

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, addiu 001001, slti 001010, andi 001100, ori 001101, lui 001111.
- Outputs not listed below are 0 in the given state.
- FETCH(0): mem_rd=1, alu_src_b=01, add. ir_wr=pc_wr=mem_ready. Next state is DECODE on mem_ready, else stay in FETCH.
- DECODE(1): alu_src_b=11, add (branch target into ALUOut).
  - lw/sw → MEM_ADR; R → EXEC; beq/bne → BRANCH; j → JUMP; jal → JAL; I-type → I_EXEC.
  - Illegal opcode: illegal=1, then TRAP (ILL_TRAP=1) or FETCH (ILL_TRAP=0).
- MEM_ADR(2): alu_src_a=1, alu_src_b=10, add. lw → MEM_RD, sw → MEM_WR.
- MEM_RD(3): mem_rd=1, iord=1. Next is MEM_WB on mem_ready. MEM_WB(4): reg_wr=1, reg_dst=00, mem_to_reg=01, then FETCH.
- MEM_WR(5): mem_wr=1, iord=1. Next is FETCH on mem_ready.
- EXEC(6): alu_src_a=1, alu_op=010, then R_WB(7). R_WB: reg_wr=1, reg_dst=01, then FETCH.
- BRANCH(8): alu_src_a=1, sub, pc_wr_cond=1, pc_src=01, br_ne=(op==bne), then FETCH.
- JUMP(9): pc_wr=1, pc_src=10, then FETCH.
- JAL(12): as JUMP, plus reg_wr=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4), then FETCH.
- I_EXEC(10): alu_src_a=1, alu_src_b=10. alu_op: addiu add, andi and (ext_zero=1), ori or (ext_zero=1), slti slt, lui lui. Next is I_WB(11).
- I_WB(11): reg_wr=1, reg_dst=00, mem_to_reg=00, then FETCH.
- TRAP(13): illegal=1, all strobes 0; exits only on reset. Unused encodings 14/15 go to FETCH.

## Timing
- All outputs are combinational from the state register (only ir_wr and pc_wr in FETCH also depend on mem_ready). Next-state logic is registered on rising clk.
- rst_n low: state=FETCH (0) immediately, asynchronously. While rst_n is low, pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_rd and mem_wr are forced to 0, and illegal is 0. After release, FETCH outputs apply from the same cycle.
- Cycles per instruction with mem_ready held 1: lw 5, sw 4, R/I-type 4, beq/bne 3, j/jal 3, illegal with ILL_TRAP=0 2. Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle with outputs held.
- Reset asserted mid-instruction aborts it. No partial register write occurs after the asserting edge.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Structure
- Package mc_cu_pkg holds:
  - opcode constants
  - the 4-bit state enum
  - alu_op codes
  - reg_dst, mem_to_reg, alu_src_b and pc_src encodings
- One sub-module, mc_cu_opdec: combinational op → {legal, class, I-type alu_op, ext_zero}, gated by EXT_EN.
- mc_cu holds the state register, next-state logic and output decode.

## Test plan
- lw, mem_ready=1 → states 0,1,2,3,4,0. MEM_WB shows reg_wr=1, mem_to_reg=01, reg_dst=00; 5 cycles total.
- sw with mem_ready low for 2 cycles in MEM_WR → mem_wr=1, iord=1 held 3 cycles; back in FETCH after 6 cycles; reg_wr never 1.
- bne (000101) → BRANCH with pc_wr_cond=1, br_ne=1, alu_op=001, pc_src=01. Repeat with beq → br_ne=0.
- jal → JAL with pc_wr=1, reg_wr=1, reg_dst=10, mem_to_reg=10, pc_src=10; ori → I_EXEC with alu_op=100, ext_zero=1.
- op=111111: with ILL_TRAP=1, TRAP holds illegal=1 for 10 cycles with strobes 0 until rst_n pulse. With ILL_TRAP=0, illegal pulses in DECODE and the FSM returns to FETCH.
- EXT_EN=0, op=jal → illegal. Separately, assert rst_n low during MEM_WB → reg_wr drops without waiting for clk, and state=0.
